pipemem_access: RTL and testbench

- MEM-stage data-memory access controller. Sits between the EX/MEM pipeline register and the MEM/WB pipeline register.
- Issues load/store requests to a data memory over a req/ready handshake and performs byte/halfword lane alignment and sign/zero extension.
- Stalls the pipeline while an access is outstanding.
- Forwards the writeback control fields (wreg, m2reg, rn, mfhi, mflo) and the ALU result to the MEM/WB register.

---
 rtl/pipemem_access.sv | 173 +++++++++++++++++
 tb/tb_pipemem_access.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipemem_access.sv
// MEM-stage data-memory access controller: issues load/store requests over a
// req/ready handshake, aligns byte/half lanes, extends loads and stalls the
// pipeline while an access is outstanding.
module pipemem_access #(
    parameter int unsigned MAX_WAIT = 16,
    parameter int unsigned CNT_W    = 5
) (
    input  logic        clk,
    input  logic        clrn,
    input  logic        mrmem,
    input  logic        mwmem,
    input  logic [1:0]  msize,
    input  logic        msigned,
    input  logic [31:0] malu_in,
    input  logic [31:0] mb,
    input  logic        mwreg_in,
    input  logic [1:0]  mm2reg_in,
    input  logic [4:0]  mrn_in,
    input  logic        mmfhi_in,
    input  logic        mmflo_in,
    output logic        dreq,
    output logic        dwe,
    output logic [31:0] daddr,
    output logic [31:0] dwdata,
    output logic [3:0]  dbe,
    input  logic [31:0] drdata,
    input  logic        dready,
    output logic [31:0] mmo,
    output logic [31:0] malu,
    output logic [4:0]  mrn,
    output logic [1:0]  mm2reg,
    output logic        mmfhi,
    output logic        mmflo,
    output logic        mwreg,
    output logic        mstall,
    output logic        mexc
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic             dreq_q, dreq_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      lrdata_q, lrdata_d;
    logic             berr_q, berr_d;

    logic        acc;
    logic        mis;
    logic [1:0]  lane;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_fmt;
    logic [3:0]  be_fmt;
    logic [31:0] wd_fmt;

    assign acc  = mrmem | mwmem;
    assign lane = malu_in[1:0];
    assign mis  = acc & (((msize == 2'b01) & malu_in[0])
                       | ((msize == 2'b10) & (malu_in[1:0] != 2'b00))
                       | (msize == 2'b11));

    // Load lane extraction and sign/zero extension from the captured read data
    always_comb begin
        ld_byte = lrdata_q[{lane, 3'b000} +: 8];
        ld_half = lrdata_q[{lane[1], 4'b0000} +: 16];
        case (msize)
            2'b00:   ld_fmt = {{24{msigned & ld_byte[7]}}, ld_byte};
            2'b01:   ld_fmt = {{16{msigned & ld_half[15]}}, ld_half};
            default: ld_fmt = lrdata_q;
        endcase
    end

    // Store lane replication and byte enables
    always_comb begin
        case (msize)
            2'b00: begin
                wd_fmt = {4{mb[7:0]}};
                be_fmt = 4'b0001 << lane;
            end
            2'b01: begin
                wd_fmt = {2{mb[15:0]}};
                be_fmt = 4'b0011 << lane;
            end
            default: begin
                wd_fmt = mb;
                be_fmt = 4'b1111;
            end
        endcase
    end

    // Next-state and MEM-stage control outputs
    always_comb begin
        state_d  = state_q;
        dreq_d   = dreq_q;
        cnt_d    = cnt_q;
        lrdata_d = lrdata_q;
        berr_d   = berr_q;
        mstall   = 1'b0;
        mexc     = 1'b0;
        mmo      = 32'd0;
        case (state_q)
            S_IDLE: begin
                if (mis) begin
                    mexc = 1'b1;
                end else if (acc) begin
                    mstall  = 1'b1;
                    state_d = S_REQ;
                    dreq_d  = 1'b1;
                    cnt_d   = '0;
                end
            end
            S_REQ: begin
                mstall = 1'b1;
                if (dready) begin
                    lrdata_d = drdata;
                    berr_d   = 1'b0;
                    dreq_d   = 1'b0;
                    state_d  = S_DONE;
                end else if (cnt_q == CNT_W'(MAX_WAIT - 1)) begin
                    berr_d  = 1'b1;
                    dreq_d  = 1'b0;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                mexc    = berr_q;
                if (mrmem & ~mwmem & ~berr_q) begin
                    mmo = ld_fmt;
                end
            end
            default: begin
                state_d = S_IDLE;
                dreq_d  = 1'b0;
            end
        endcase
    end

    // State registers with synchronous reset abandoning any outstanding request
    always_ff @(posedge clk) begin
        if (clrn) begin
            state_q  <= S_IDLE;
            dreq_q   <= 1'b0;
            cnt_q    <= '0;
            lrdata_q <= 32'd0;
            berr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            dreq_q   <= dreq_d;
            cnt_q    <= cnt_d;
            lrdata_q <= lrdata_d;
            berr_q   <= berr_d;
        end
    end

    assign dreq   = dreq_q;
    assign dwe    = dreq_q & mwmem;
    assign dbe    = dreq_q ? be_fmt : 4'b0000;
    assign daddr  = {malu_in[31:2], 2'b00};
    assign dwdata = wd_fmt;

    assign malu   = malu_in;
    assign mrn    = mrn_in;
    assign mm2reg = mm2reg_in;
    assign mmfhi  = mmfhi_in;
    assign mmflo  = mmflo_in;
    assign mwreg  = mwreg_in & ~mexc;

endmodule

// File: tb/tb_pipemem_access.sv
// Self-checking bench for pipemem_access: directed test-plan scenarios plus
// randomized accesses checked against a byte-level behavioural model.
module tb_pipemem_access;

    localparam int MAXW = 16;

    logic        clk = 1'b0;
    logic        clrn;
    logic        mrmem, mwmem, msigned, mwreg_in, mmfhi_in, mmflo_in, dready;
    logic [1:0]  msize, mm2reg_in;
    logic [4:0]  mrn_in;
    logic [31:0] malu_in, mb, drdata;
    logic        dreq, dwe, mwreg, mstall, mexc, mmfhi, mmflo;
    logic [31:0] daddr, dwdata, mmo, malu;
    logic [3:0]  dbe;
    logic [4:0]  mrn;
    logic [1:0]  mm2reg;

    int errors = 0;
    int checks = 0;

    // Observations of the last run_access call
    int          r_stall, r_req;
    logic        r_to, r_we, r_exc, r_wreg, r_done_we;
    logic [31:0] r_addr, r_wdata, r_mmo;
    logic [3:0]  r_be, r_done_be;

    pipemem_access #(.MAX_WAIT(16), .CNT_W(5)) dut (
        .clk(clk), .clrn(clrn), .mrmem(mrmem), .mwmem(mwmem), .msize(msize),
        .msigned(msigned), .malu_in(malu_in), .mb(mb), .mwreg_in(mwreg_in),
        .mm2reg_in(mm2reg_in), .mrn_in(mrn_in), .mmfhi_in(mmfhi_in), .mmflo_in(mmflo_in),
        .dreq(dreq), .dwe(dwe), .daddr(daddr), .dwdata(dwdata), .dbe(dbe),
        .drdata(drdata), .dready(dready), .mmo(mmo), .malu(malu), .mrn(mrn),
        .mm2reg(mm2reg), .mmfhi(mmfhi), .mmflo(mmflo), .mwreg(mwreg),
        .mstall(mstall), .mexc(mexc)
    );

    always #5 clk = ~clk;

    // Little-endian byte view of the read word, then lane pick and extension
    function automatic logic [31:0] model_load(input logic [31:0] d, input logic [1:0] sz,
                                               input logic sg, input logic [31:0] a);
        logic [7:0]  by [4];
        logic [31:0] v;
        int          lo;
        for (int i = 0; i < 4; i++) by[i] = d[8*i +: 8];
        lo = int'(a[1:0]);
        if (sz == 2'b10) return d;
        if (sz == 2'b00) begin
            v = {24'd0, by[lo]};
            if (sg && by[lo][7]) v[31:8] = '1;
        end else begin
            lo = lo & 2;
            v = {16'd0, by[lo+1], by[lo]};
            if (sg && by[lo+1][7]) v[31:16] = '1;
        end
        return v;
    endfunction

    function automatic int size_bytes(input logic [1:0] sz);
        return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    endfunction

    function automatic logic [3:0] model_be(input logic [1:0] sz, input logic [31:0] a);
        logic [3:0] be;
        int lo, nb;
        nb = size_bytes(sz);
        lo = (nb == 4) ? 0 : int'(a[1:0]);
        for (int i = 0; i < 4; i++) be[i] = (i >= lo) && (i < lo + nb);
        return be;
    endfunction

    function automatic logic [31:0] model_wdata(input logic [1:0] sz, input logic [31:0] b);
        logic [31:0] w;
        int nb;
        nb = size_bytes(sz);
        for (int i = 0; i < 4; i++) w[8*i +: 8] = b[8*(i % nb) +: 8];
        return w;
    endfunction

    // Present one MEM-stage instruction; memory answers in REQ cycle 'lat' (0 = never).
    // Entered and left at posedge+1.
    task automatic run_access(input logic rd, input logic wr, input logic [1:0] sz,
                              input logic sg, input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] rdata, input int lat);
        mrmem = rd; mwmem = wr; msize = sz; msigned = sg; malu_in = a; mb = b;
        mwreg_in = 1'b1; dready = 1'b0;
        r_stall = 0; r_req = 0; r_to = 1'b1; r_we = 1'b0; r_addr = '0; r_wdata = '0;
        r_be = '0; r_mmo = '0; r_exc = 1'b0; r_wreg = 1'b0; r_done_be = '0; r_done_we = 1'b0;
        for (int cyc = 0; cyc < 64; cyc++) begin
            #2;
            if (dreq) begin
                r_req++;
                r_addr = daddr; r_wdata = dwdata; r_be = dbe; r_we = dwe;
                if (r_req == lat) begin dready = 1'b1; drdata = rdata; end
                else drdata = $urandom;
            end
            if (mstall) r_stall++;
            else begin
                r_mmo = mmo; r_exc = mexc; r_wreg = mwreg;
                r_done_be = dbe; r_done_we = dwe; r_to = 1'b0;
            end
            @(posedge clk); #1;
            dready = 1'b0;
            if (!r_to) break;
        end
        mrmem = 1'b0; mwmem = 1'b0;
    endtask

    task automatic test_reset;
        clrn = 1'b1;
        repeat (2) @(posedge clk);
        #1 clrn = 1'b0;
        #2;
        checks++; if (dreq !== 1'b0) begin errors++; $display("FAIL reset_dreq: got %b want 0", dreq); end
        checks++; if (mstall !== 1'b0) begin errors++; $display("FAIL reset_mstall: got %b want 0", mstall); end
        checks++; if (dbe !== 4'b0000 || dwe !== 1'b0) begin errors++; $display("FAIL reset_dbe_dwe: got %b/%b want 0000/0", dbe, dwe); end
        checks++; if (mexc !== 1'b0 || mmo !== 32'd0) begin errors++; $display("FAIL reset_mexc_mmo: got %b/%h want 0/0", mexc, mmo); end
        @(posedge clk); #1;
    endtask

    task automatic test_passthrough;
        logic [31:0] a; logic [4:0] rn; logic [1:0] m2; logic hi, lo, wr;
        for (int i = 0; i < 4; i++) begin
            a = $urandom; rn = 5'($urandom); m2 = 2'($urandom); hi = 1'($urandom);
            lo = 1'($urandom); wr = 1'($urandom);
            malu_in = a; mrn_in = rn; mm2reg_in = m2; mmfhi_in = hi; mmflo_in = lo; mwreg_in = wr;
            #2;
            checks++;
            if (malu !== a || mrn !== rn || mm2reg !== m2 || mmfhi !== hi || mmflo !== lo || mwreg !== wr || mmo !== 32'd0) begin
                errors++;
                $display("FAIL passthrough: got %h %h %h %b %b %b mmo=%h want %h %h %h %b %b %b mmo=0",
                         malu, mrn, mm2reg, mmfhi, mmflo, mwreg, mmo, a, rn, m2, hi, lo, wr);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_word_load;
        run_access(1'b1, 1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 1);
        checks++; if (r_addr !== 32'h100) begin errors++; $display("FAIL lw_daddr: got %h want 00000100", r_addr); end
        checks++; if (r_stall !== 2) begin errors++; $display("FAIL lw_stall: got %0d want 2", r_stall); end
        checks++; if (r_mmo !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_mmo: got %h want deadbeef", r_mmo); end
        checks++; if (r_wreg !== 1'b1 || r_exc !== 1'b0) begin errors++; $display("FAIL lw_wreg_exc: got %b/%b want 1/0", r_wreg, r_exc); end
        checks++; if (r_we !== 1'b0) begin errors++; $display("FAIL lw_dwe: got %b want 0", r_we); end
    endtask

    task automatic test_signed_loads;
        run_access(1'b1, 1'b0, 2'b00, 1'b1, 32'h103, 32'h0, 32'h80FF0000, 1);
        checks++; if (r_mmo !== 32'hFFFFFF80) begin errors++; $display("FAIL lb_mmo: got %h want ffffff80", r_mmo); end
        run_access(1'b1, 1'b0, 2'b00, 1'b0, 32'h103, 32'h0, 32'h80FF0000, 1);
        checks++; if (r_mmo !== 32'h00000080) begin errors++; $display("FAIL lbu_mmo: got %h want 00000080", r_mmo); end
        run_access(1'b1, 1'b0, 2'b01, 1'b1, 32'h102, 32'h0, 32'h80FF0000, 1);
        checks++; if (r_mmo !== 32'hFFFF80FF) begin errors++; $display("FAIL lh_mmo: got %h want ffff80ff", r_mmo); end
        run_access(1'b1, 1'b0, 2'b01, 1'b0, 32'h100, 32'h0, 32'h1234F00D, 2);
        checks++; if (r_mmo !== 32'h0000F00D) begin errors++; $display("FAIL lhu_mmo: got %h want 0000f00d", r_mmo); end
    endtask

    task automatic test_stores;
        run_access(1'b0, 1'b1, 2'b00, 1'b0, 32'h201, 32'h12345678, 32'h0, 1);
        checks++; if (r_we !== 1'b1) begin errors++; $display("FAIL sb_dwe: got %b want 1", r_we); end
        checks++; if (r_be !== 4'b0010) begin errors++; $display("FAIL sb_dbe: got %b want 0010", r_be); end
        checks++; if (r_wdata !== 32'h78787878) begin errors++; $display("FAIL sb_dwdata: got %h want 78787878", r_wdata); end
        checks++; if (r_addr !== 32'h200) begin errors++; $display("FAIL sb_daddr: got %h want 00000200", r_addr); end
        checks++; if (r_done_be !== 4'b0000 || r_done_we !== 1'b0) begin errors++; $display("FAIL sb_idle_dbe_dwe: got %b/%b want 0000/0", r_done_be, r_done_we); end
        run_access(1'b0, 1'b1, 2'b01, 1'b0, 32'h202, 32'h12345678, 32'h0, 1);
        checks++; if (r_be !== 4'b1100) begin errors++; $display("FAIL sh_dbe: got %b want 1100", r_be); end
        checks++; if (r_wdata !== 32'h56785678) begin errors++; $display("FAIL sh_dwdata: got %h want 56785678", r_wdata); end
        run_access(1'b1, 1'b1, 2'b10, 1'b0, 32'h300, 32'hA5A5_5A5A, 32'hFFFF_FFFF, 1);
        checks++; if (r_we !== 1'b1 || r_mmo !== 32'd0) begin errors++; $display("FAIL both_rw: got dwe=%b mmo=%h want dwe=1 mmo=0", r_we, r_mmo); end
    endtask

    task automatic test_misaligned;
        run_access(1'b1, 1'b0, 2'b10, 1'b0, 32'h101, 32'h0, 32'h0, 1);
        checks++; if (r_req !== 0 || r_stall !== 0) begin errors++; $display("FAIL lw_mis_req: got req=%0d stall=%0d want 0/0", r_req, r_stall); end
        checks++; if (r_exc !== 1'b1 || r_wreg !== 1'b0 || r_mmo !== 32'd0) begin errors++; $display("FAIL lw_mis_exc: got exc=%b wreg=%b mmo=%h want 1/0/0", r_exc, r_wreg, r_mmo); end
        #2;
        checks++; if (mexc !== 1'b0) begin errors++; $display("FAIL lw_mis_oneshot: got %b want 0", mexc); end
        @(posedge clk); #1;
        run_access(1'b1, 1'b0, 2'b01, 1'b1, 32'h103, 32'h0, 32'h0, 1);
        checks++; if (r_req !== 0 || r_stall !== 0 || r_exc !== 1'b1 || r_wreg !== 1'b0) begin errors++; $display("FAIL lh_mis: got req=%0d stall=%0d exc=%b wreg=%b want 0/0/1/0", r_req, r_stall, r_exc, r_wreg); end
    endtask

    task automatic test_timeout;
        run_access(1'b1, 1'b0, 2'b10, 1'b0, 32'h400, 32'h0, 32'h11223344, 0);
        checks++; if (r_to !== 1'b0 || r_req !== MAXW) begin errors++; $display("FAIL tmo_cycles: got req=%0d hung=%b want %0d/0", r_req, r_to, MAXW); end
        checks++; if (r_exc !== 1'b1 || r_wreg !== 1'b0 || r_mmo !== 32'd0) begin errors++; $display("FAIL tmo_exc: got exc=%b wreg=%b mmo=%h want 1/0/0", r_exc, r_wreg, r_mmo); end
        run_access(1'b1, 1'b0, 2'b10, 1'b0, 32'h400, 32'h0, 32'h11223344, MAXW);
        checks++; if (r_req !== MAXW || r_exc !== 1'b0 || r_mmo !== 32'h11223344) begin errors++; $display("FAIL tmo_edge: got req=%0d exc=%b mmo=%h want %0d/0/11223344", r_req, r_exc, r_mmo, MAXW); end
    endtask

    task automatic test_reset_mid_access;
        mrmem = 1'b1; mwmem = 1'b0; msize = 2'b10; malu_in = 32'h100; mwreg_in = 1'b1; dready = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        #2;
        checks++; if (dreq !== 1'b1) begin errors++; $display("FAIL rst_mid_pre: got dreq=%b want 1", dreq); end
        clrn = 1'b1;
        @(posedge clk); #1;
        clrn = 1'b0; mrmem = 1'b0;
        #2;
        checks++; if (dreq !== 1'b0 || mstall !== 1'b0 || dbe !== 4'b0000) begin errors++; $display("FAIL rst_mid_idle: got dreq=%b mstall=%b dbe=%b want 0/0/0000", dreq, mstall, dbe); end
        dready = 1'b1; drdata = 32'hCAFEF00D;
        @(posedge clk); #1;
        dready = 1'b0;
        #2;
        checks++; if (dreq !== 1'b0 || mstall !== 1'b0 || mexc !== 1'b0 || mmo !== 32'd0) begin errors++; $display("FAIL rst_stale_dready: got dreq=%b mstall=%b mexc=%b mmo=%h want 0/0/0/0", dreq, mstall, mexc, mmo); end
        @(posedge clk); #1;
    endtask

    task automatic test_random;
        logic rd, wr, sg, acc, mis, tmo;
        logic [1:0] sz;
        logic [31:0] a, b, d, e_mmo;
        int kind, lat, eff, e_stall;
        for (int n = 0; n < 40; n++) begin
            kind = $urandom_range(0, 9);
            rd = (kind == 1) || (kind >= 2 && kind <= 5);
            wr = (kind == 1) || (kind >= 6);
            sz = 2'($urandom);
            if (sz == 2'b11 && $urandom_range(0, 3) != 0) sz = 2'b10;
            sg = 1'($urandom); a = $urandom; b = $urandom; d = $urandom;
            if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
            lat = $urandom_range(1, MAXW + 2);
            acc = rd | wr;
            mis = acc && (sz == 2'b11 || (int'(a[1:0]) % size_bytes(sz)) != 0);
            tmo = lat > MAXW;
            eff = tmo ? MAXW : lat;
            run_access(rd, wr, sz, sg, a, b, d, lat);
            if (!acc || mis) begin
                checks++;
                if (r_stall !== 0 || r_req !== 0 || r_exc !== mis || r_wreg !== !mis || r_mmo !== 32'd0) begin
                    errors++;
                    $display("FAIL rnd_noreq[%0d]: got stall=%0d req=%0d exc=%b wreg=%b mmo=%h want 0/0/%b/%b/0", n, r_stall, r_req, r_exc, r_wreg, r_mmo, mis, !mis);
                end
            end else begin
                e_stall = eff + 1;
                e_mmo = (rd && !wr && !tmo) ? model_load(d, sz, sg, a) : 32'd0;
                checks++;
                if (r_stall !== e_stall || r_req !== eff || r_exc !== tmo || r_wreg !== !tmo) begin
                    errors++;
                    $display("FAIL rnd_timing[%0d]: got stall=%0d req=%0d exc=%b wreg=%b want %0d/%0d/%b/%b", n, r_stall, r_req, r_exc, r_wreg, e_stall, eff, tmo, !tmo);
                end
                checks++;
                if (r_mmo !== e_mmo) begin errors++; $display("FAIL rnd_mmo[%0d]: got %h want %h", n, r_mmo, e_mmo); end
                checks++;
                if (r_addr !== {a[31:2], 2'b00} || r_be !== model_be(sz, a) || r_we !== wr) begin
                    errors++;
                    $display("FAIL rnd_bus[%0d]: got addr=%h be=%b we=%b want %h/%b/%b", n, r_addr, r_be, r_we, {a[31:2], 2'b00}, model_be(sz, a), wr);
                end
                if (wr) begin
                    checks++;
                    if (r_wdata !== model_wdata(sz, b)) begin errors++; $display("FAIL rnd_wdata[%0d]: got %h want %h", n, r_wdata, model_wdata(sz, b)); end
                end
            end
        end
    endtask

    initial begin
        mrmem = 1'b0; mwmem = 1'b0; msize = 2'b10; msigned = 1'b0; malu_in = '0; mb = '0;
        mwreg_in = 1'b0; mm2reg_in = '0; mrn_in = '0; mmfhi_in = 1'b0; mmflo_in = 1'b0;
        dready = 1'b0; drdata = '0; clrn = 1'b1;
        test_reset;
        test_passthrough;
        test_word_load;
        test_signed_loads;
        test_stores;
        test_misaligned;
        test_timeout;
        test_reset_mid_access;
        test_random;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
